// File: rtl/hc_sr04_pkg.sv
// Shared definitions for the HC-SR04 scan controller: FSM state encoding,
// default timing constants, distance width and the timeout distance code.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT,
        S_HOLD
    } scan_state_t;

    // Distance width in cm, wide enough for the 400 cm sensor range.
    localparam int DST_SZ_DEF  = 9;
    // No-echo timeout: 680 strobes of 58.82 us, about 40 ms.
    localparam int TMO_ST_DEF  = 680;
    // Crosstalk holdoff between measurements: 1020 strobes, about 60 ms.
    localparam int HOLD_ST_DEF = 1020;

    // Distance reported when a sensor never answers.
    localparam logic [DST_SZ_DEF-1:0] DST_TMO_CODE = '1;

    // One strobe counter serves both the timeout and the holdoff.
    function automatic int strobe_cnt_w(input int tmo_st, input int hold_st);
        return $clog2(((tmo_st > hold_st) ? tmo_st : hold_st) + 1);
    endfunction

endpackage

// File: rtl/hc_sr04_scan_ctrl_if.sv
// Result stream from the scan controller toward BCD/display logic.
// The controller drives vld/ch/dst/tmo, the consumer drives rdy.
interface hc_sr04_scan_ctrl_if
    import hc_sr04_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DST_SZ = DST_SZ_DEF
);
    logic                    vld;
    logic                    rdy;
    logic [$clog2(N_CH)-1:0] ch;
    logic [DST_SZ-1:0]       dst;
    logic                    tmo;

    modport master (output vld, ch, dst, tmo, input rdy);
    modport slave  (input vld, ch, dst, tmo, output rdy);
endinterface

// File: rtl/hc_sr04_scan_ctrl_rr_next_ch.sv
// Combinational round-robin finder: returns the nearest eligible channel
// starting at cur (incl=1) or just after cur (incl=0), wrapping N_CH-1 -> 0.
// any is high when at least one channel is eligible; otherwise nxt=cur.
module rr_next_ch
    import hc_sr04_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [$clog2(N_CH)-1:0] cur,
    input  logic                    incl,
    input  logic [N_CH-1:0]         elig,
    output logic [$clog2(N_CH)-1:0] nxt,
    output logic                    any
);
    localparam int CH_W = $clog2(N_CH);

    logic [CH_W-1:0] cand;

    // Walk offsets far-to-near so the nearest eligible candidate is written last.
    always_comb begin
        // NOTE: every comb output gets a default before the loop so no path infers a latch.
        nxt  = cur;
        cand = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = CH_W'((int'(cur) + (incl ? 0 : 1) + k) % N_CH);
            if (elig[cand]) begin
                nxt = cand;
            end
        end
    end

    assign any = |elig;

endmodule

// File: rtl/hc_sr04_scan_ctrl.sv
// Round-robin scheduler sharing one HC-SR04 measurement FSM among N_CH sensors.
// One measurement runs at a time: the trigger is steered to the selected sensor,
// its echo is steered back, and each result leaves tagged with its channel.
// A no-echo timeout and an inter-measurement crosstalk holdoff are enforced in
// units of the 58.82 us strobe.
// Optional feature: define HC_SR04_SCAN_MASK_EN to add ch_mask, a per-channel
// eligibility mask; without it every channel is eligible.
module hc_sr04_scan_ctrl
    import hc_sr04_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DST_SZ  = DST_SZ_DEF,
    parameter int TMO_ST  = TMO_ST_DEF,
    parameter int HOLD_ST = HOLD_ST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic                run,
    input  logic [N_CH-1:0]     sensor_echo,
    output logic                fsm_echo,
    input  logic                fsm_trig,
    output logic [N_CH-1:0]     sensor_trig,
    output logic                meas_en,
    input  logic                meas_done,
    input  logic [DST_SZ-1:0]   meas_dst,
`ifdef HC_SR04_SCAN_MASK_EN
    input  logic [N_CH-1:0]     ch_mask,
`endif
    output logic                busy,
    hc_sr04_scan_ctrl_if.master res
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = strobe_cnt_w(TMO_ST, HOLD_ST);

    scan_state_t       state, state_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DST_SZ-1:0] dst_q;
    logic              tmo_q;
    logic [N_CH-1:0]   elig;
    logic [CH_W-1:0]   rr_ch;
    logic              rr_any;
    logic              tmo_hit;
    logic              hold_hit;

`ifdef HC_SR04_SCAN_MASK_EN
    assign elig = ch_mask;
`else
    assign elig = '1;
`endif

    // From IDLE the current channel is itself a candidate (so the first scan
    // after reset starts at channel 0); on leaving HOLD the search starts after it.
    rr_next_ch #(.N_CH(N_CH)) u_rr (
        .cur  (ch),
        .incl (state == S_IDLE),
        .elig (elig),
        .nxt  (rr_ch),
        .any  (rr_any)
    );

    // The strobe that completes the count is the one that fires the event.
    assign tmo_hit  = (state == S_WAIT) && st && (cnt == CNT_W'(TMO_ST - 1));
    assign hold_hit = (state == S_HOLD) && st && (cnt == CNT_W'(HOLD_ST - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        meas_en     = 1'b0;
        busy        = 1'b1;
        res.vld     = 1'b0;
        sensor_trig = '0;
        fsm_echo    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run && rr_any) begin
                    state_nxt = S_START;
                    ch_nxt    = rr_ch;
                end
            end
            S_START: begin
                meas_en     = 1'b1;
                sensor_trig = {N_CH{fsm_trig}} & (N_CH'(1) << ch);
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                sensor_trig = {N_CH{fsm_trig}} & (N_CH'(1) << ch);
                fsm_echo    = sensor_echo[ch];
                if (meas_done || tmo_hit) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                res.vld = 1'b1;
                if (res.rdy) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_hit) begin
                    // Advance even when stopping so a later restart resumes after ch.
                    if (rr_any) begin
                        ch_nxt = rr_ch;
                    end
                    state_nxt = (run && rr_any) ? S_START : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Channel pointer; holds through OUT so the result tag is stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch <= '0;
        end else begin
            ch <= ch_nxt;
        end
    end

    // Strobe counter: cleared at START and on entering OUT, counts in WAIT and HOLD only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_START || (state == S_WAIT && state_nxt == S_OUT)) begin
            cnt <= '0;
        end else if (st && (state == S_WAIT || state == S_HOLD)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Result capture; a distance arriving on the timeout strobe takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q <= '0;
            tmo_q <= 1'b0;
        end else if (state == S_WAIT) begin
            if (meas_done) begin
                dst_q <= meas_dst;
                tmo_q <= 1'b0;
            end else if (tmo_hit) begin
                dst_q <= {DST_SZ{1'b1}};
                tmo_q <= 1'b1;
            end
        end
    end

    assign res.ch  = ch;
    assign res.dst = dst_q;
    assign res.tmo = tmo_q;

endmodule
